// File: rtl/csc_matrix_3x3.sv
// 3x3 colour-space converter, out_k = clamp(sum_j C[k][j]*in_j + O[k]), 4-cycle latency, full throughput.
// Build option CSC_ROUND_EN: round half up before the normalising shift (default: floor).
module csc_matrix_3x3 #(
  parameter int DW   = 8,
  parameter int CW   = 12,
  parameter int FRAC = 9,
  parameter logic signed [CW-1:0] C11 = 12'sd153,
  parameter logic signed [CW-1:0] C12 = 12'sd301,
  parameter logic signed [CW-1:0] C13 = 12'sd58,
  parameter logic signed [CW-1:0] C21 = -12'sd86,
  parameter logic signed [CW-1:0] C22 = -12'sd170,
  parameter logic signed [CW-1:0] C23 = 12'sd256,
  parameter logic signed [CW-1:0] C31 = 12'sd256,
  parameter logic signed [CW-1:0] C32 = -12'sd214,
  parameter logic signed [CW-1:0] C33 = -12'sd42,
  parameter logic signed [CW-1:0] O1  = 12'sd0,
  parameter logic signed [CW-1:0] O2  = 12'sd128,
  parameter logic signed [CW-1:0] O3  = 12'sd128
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic [DW-1:0] iC0,
  input  logic [DW-1:0] iC1,
  input  logic [DW-1:0] iC2,
  input  logic          iHSync,
  input  logic          iVSync,
  input  logic          iLineValid,
  input  logic          iFrameValid,
  input  logic          iCoefWe,
  input  logic [3:0]    iCoefAddr,
  input  logic [CW-1:0] iCoefData,
  input  logic          iCoefCommit,
  output logic [DW-1:0] oC0,
  output logic [DW-1:0] oC1,
  output logic [DW-1:0] oC2,
  output logic          oHSync,
  output logic          oVSync,
  output logic          oLineValid,
  output logic          oFrameValid,
  output logic          oCoefPending
);

  localparam int LAT  = 4;
  localparam int NREG = 12;
  localparam int PW   = DW + CW + 1;
  localparam int SW   = PW + 2;
`ifdef CSC_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC - 1);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  function automatic logic signed [CW-1:0] f_reset_coef(input logic [3:0] idx);
    case (idx)
      4'd0:    return C11;
      4'd1:    return C12;
      4'd2:    return C13;
      4'd3:    return C21;
      4'd4:    return C22;
      4'd5:    return C23;
      4'd6:    return C31;
      4'd7:    return C32;
      4'd8:    return C33;
      4'd9:    return O1;
      4'd10:   return O2;
      4'd11:   return O3;
      default: return '0;
    endcase
  endfunction

  logic signed [CW-1:0] r_shadow     [NREG];
  logic signed [CW-1:0] r_active     [NREG];
  logic signed [CW-1:0] w_shadow_nxt [NREG];
  logic signed [CW-1:0] w_active_nxt [NREG];
  logic                 r_pending;
  logic                 w_pending_nxt;
  logic                 w_copy;

  logic signed [DW:0]   w_px   [3];
  logic signed [PW-1:0] r_prod [3][3];
  logic signed [CW-1:0] r_off  [3];
  logic signed [SW-1:0] r_sa   [3];
  logic signed [SW-1:0] r_sb   [3];
  logic signed [SW-1:0] w_sum  [3];
  logic signed [SW-1:0] w_shr  [3];
  logic signed [SW-1:0] r_s3   [3];
  logic [DW-1:0]        w_sat  [3];
  logic [DW-1:0]        r_out  [3];
  logic [LAT-1:0][3:0]  r_sync;

  // Bank update: the copy sees a same-edge shadow write, and the pixel sampled on the copy edge uses the new bank.
  always_comb begin
    w_copy = r_pending & ~iFrameValid;
    for (int i = 0; i < NREG; i++) begin
      if (iCoefWe && (iCoefAddr == 4'(i))) begin
        w_shadow_nxt[i] = iCoefData;
      end else begin
        w_shadow_nxt[i] = r_shadow[i];
      end
      if (w_copy) begin
        w_active_nxt[i] = w_shadow_nxt[i];
      end else begin
        w_active_nxt[i] = r_active[i];
      end
    end
    if (w_copy) begin
      w_pending_nxt = 1'b0;
    end else if (iCoefCommit) begin
      w_pending_nxt = 1'b1;
    end else begin
      w_pending_nxt = r_pending;
    end
  end

  // Shadow/active coefficient banks and commit flag.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_shadow[i] <= f_reset_coef(4'(i));
        r_active[i] <= f_reset_coef(4'(i));
      end
      r_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        r_active[i] <= w_active_nxt[i];
      end
      r_pending <= w_pending_nxt;
    end
  end

  // Pixels enter as non-negative signed operands; normalise, then clamp to the unsigned output range.
  always_comb begin
    w_px[0] = {1'b0, iC0};
    w_px[1] = {1'b0, iC1};
    w_px[2] = {1'b0, iC2};
    for (int k = 0; k < 3; k++) begin
      w_sum[k] = r_sa[k] + r_sb[k] + RND;
      w_shr[k] = w_sum[k] >>> FRAC;
      if (r_s3[k][SW-1]) begin
        w_sat[k] = '0;
      end else if (|r_s3[k][SW-2:DW]) begin
        w_sat[k] = '1;
      end else begin
        w_sat[k] = r_s3[k][DW-1:0];
      end
    end
  end

  // Four-stage datapath; offsets travel with their pixel so a bank copy never mixes old and new terms.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 3; j++) begin
          r_prod[k][j] <= '0;
        end
        r_off[k] <= '0;
        r_sa[k]  <= '0;
        r_sb[k]  <= '0;
        r_s3[k]  <= '0;
        r_out[k] <= '0;
      end
      r_sync <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 3; j++) begin
          r_prod[k][j] <= PW'(w_px[j]) * PW'(w_active_nxt[3*k+j]);
        end
        r_off[k] <= w_active_nxt[9+k];
        r_sa[k]  <= SW'(r_prod[k][0]) + SW'(r_prod[k][1]);
        r_sb[k]  <= SW'(r_prod[k][2]) + (SW'(r_off[k]) <<< FRAC);
        r_s3[k]  <= w_shr[k];
        r_out[k] <= w_sat[k];
      end
      r_sync <= {r_sync[LAT-2:0], iHSync, iVSync, iLineValid, iFrameValid};
    end
  end

  assign oC0          = r_out[0];
  assign oC1          = r_out[1];
  assign oC2          = r_out[2];
  assign oHSync       = r_sync[LAT-1][3];
  assign oVSync       = r_sync[LAT-1][2];
  assign oLineValid   = r_sync[LAT-1][1];
  assign oFrameValid  = r_sync[LAT-1][0];
  assign oCoefPending = r_pending;

endmodule

// File: tb/tb_csc_matrix_3x3.sv
// Self-checking bench for csc_matrix_3x3: directed spec vectors plus randomized traffic against an
// arithmetic reference model (integer matrix product, floor/round, clamp, 4-deep output queue).
module tb_csc_matrix_3x3;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic [7:0]  iC0 = '0, iC1 = '0, iC2 = '0;
  logic        iHSync = 1'b0, iVSync = 1'b0, iLineValid = 1'b0, iFrameValid = 1'b0;
  logic        iCoefWe = 1'b0;
  logic [3:0]  iCoefAddr = '0;
  logic [11:0] iCoefData = '0;
  logic        iCoefCommit = 1'b0;
  logic [7:0]  oC0, oC1, oC2;
  logic        oHSync, oVSync, oLineValid, oFrameValid, oCoefPending;

  csc_matrix_3x3 dut (
    .iClk(iClk), .iRst_n(iRst_n), .iC0(iC0), .iC1(iC1), .iC2(iC2),
    .iHSync(iHSync), .iVSync(iVSync), .iLineValid(iLineValid), .iFrameValid(iFrameValid),
    .iCoefWe(iCoefWe), .iCoefAddr(iCoefAddr), .iCoefData(iCoefData), .iCoefCommit(iCoefCommit),
    .oC0(oC0), .oC1(oC1), .oC2(oC2),
    .oHSync(oHSync), .oVSync(oVSync), .oLineValid(oLineValid), .oFrameValid(oFrameValid),
    .oCoefPending(oCoefPending)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: {sync[3:0], c0, c1, c2} per output slot
  int          defc [12] = '{153, 301, 58, -86, -170, 256, 256, -214, -42, 0, 128, 128};
  int          sh [12];
  int          ac [12];
  bit          pend;
  logic [27:0] q [$];
  logic [27:0] e_vec;
  bit          e_pend;
  logic [27:0] obs;

  assign obs = {oHSync, oVSync, oLineValid, oFrameValid, oC0, oC1, oC2};

  function automatic int f_cvt(int k, int p0, int p1, int p2);
    longint s;
    s = longint'(ac[3*k]) * p0 + longint'(ac[3*k+1]) * p1 + longint'(ac[3*k+2]) * p2
      + longint'(ac[9+k]) * 512;
`ifdef CSC_ROUND_EN
    s = s + 256;
`endif
    s = s >>> 9;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      sh[i] = defc[i];
      ac[i] = defc[i];
    end
    pend = 1'b0;
    q.delete();
    repeat (3) q.push_back(28'h0);
  endtask

  // Drive one input cycle, advance the model across the edge, and publish the expected outputs.
  task automatic step(input int p0, input int p1, input int p2, input logic [3:0] sy,
                      input logic we, input int addr, input int data, input logic cm);
    int nsh [12];
    logic [27:0] v;
    logic [7:0] y0, y1, y2;
    iC0 = p0[7:0]; iC1 = p1[7:0]; iC2 = p2[7:0];
    {iHSync, iVSync, iLineValid, iFrameValid} = sy;
    iCoefWe = we; iCoefAddr = addr[3:0]; iCoefData = data[11:0]; iCoefCommit = cm;
    nsh = sh;
    if (we && addr < 12) nsh[addr] = data;
    if (pend && !sy[0]) begin
      ac = nsh;
      pend = 1'b0;
    end else if (cm) begin
      pend = 1'b1;
    end
    sh = nsh;
    y0 = 8'(f_cvt(0, p0, p1, p2));
    y1 = 8'(f_cvt(1, p0, p1, p2));
    y2 = 8'(f_cvt(2, p0, p1, p2));
    v = {sy, y0, y1, y2};
    q.push_back(v);
    @(posedge iClk); #1;
    e_vec  = q.pop_front();
    e_pend = pend;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    iC0 = 8'd200; iC1 = 8'd10; iC2 = 8'd99;
    {iHSync, iVSync, iLineValid, iFrameValid} = 4'b1111;
    repeat (3) @(posedge iClk);
    #1;
    model_reset();
    n_checks++;
    if (obs !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 28'h0);
    end
    n_checks++;
    if (oCoefPending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pending: got %b expected 0", oCoefPending);
    end
    iRst_n = 1'b1;
  endtask

  task automatic test_vectors();
    int vin [3][3];
    int vexp [3][3];
    vin  = '{'{255, 255, 255}, '{255, 0, 0}, '{1, 0, 0}};
`ifdef CSC_ROUND_EN
    vexp = '{'{255, 128, 128}, '{76, 85, 255}, '{0, 128, 129}};
`else
    vexp = '{'{255, 128, 128}, '{76, 85, 255}, '{0, 127, 128}};
`endif
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) step(vin[v][0], vin[v][1], vin[v][2], 4'b0011, 1'b0, 0, 0, 1'b0);
        else        step(0, 0, 0, 4'b0011, 1'b0, 0, 0, 1'b0);
        n_checks++;
        if (obs !== e_vec) begin
          n_fail++;
          $display("FAIL vec%0d_cycle%0d: got %h expected %h", v, c, obs, e_vec);
        end
      end
      n_checks++;
      if ({oC0, oC1, oC2} !== {8'(vexp[v][0]), 8'(vexp[v][1]), 8'(vexp[v][2])}) begin
        n_fail++;
        $display("FAIL vec%0d_value: got %0d,%0d,%0d expected %0d,%0d,%0d",
                 v, oC0, oC1, oC2, vexp[v][0], vexp[v][1], vexp[v][2]);
      end
    end
  endtask

  task automatic test_coef_update();
    step(255, 0, 0, 4'b0011, 1'b1, 0, 1024, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(255, 0, 0, 4'b0011, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (oCoefPending !== 1'b1 || obs !== e_vec) begin
        n_fail++;
        $display("FAIL commit_held_in_frame: got pend=%b out=%h expected pend=1 out=%h",
                 oCoefPending, obs, e_vec);
      end
    end
    n_checks++;
    if (oC0 !== 8'd76) begin
      n_fail++;
      $display("FAIL old_coef_in_frame: got %0d expected 76", oC0);
    end
    step(0, 0, 0, 4'b0000, 1'b0, 0, 0, 1'b0);
    n_checks++;
    if (oCoefPending !== 1'b0 || e_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_applied: got pend=%b expected 0", oCoefPending);
    end
    step(200, 0, 0, 4'b0011, 1'b0, 0, 0, 1'b0);
    step(100, 0, 0, 4'b0011, 1'b0, 0, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 4'b0011, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== e_vec) begin
        n_fail++;
        $display("FAIL new_coef_cycle%0d: got %h expected %h", c, obs, e_vec);
      end
      if (c == 1) begin
        n_checks++;
        if (oC0 !== 8'd255) begin
          n_fail++;
          $display("FAIL new_coef_clamp: got %0d expected 255", oC0);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (oC0 !== 8'd200) begin
          n_fail++;
          $display("FAIL new_coef_gain2: got %0d expected 200", oC0);
        end
      end
    end
  endtask

  task automatic test_hsync();
    for (int i = 0; i < 12; i++) begin
      step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           {(i == 4), 1'b0, 1'b1, 1'b1}, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (oHSync !== (i == 7) || obs !== e_vec) begin
        n_fail++;
        $display("FAIL hsync_align_%0d: got hs=%b out=%h expected hs=%b out=%h",
                 i, oHSync, obs, (i == 7), e_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] sy;
      sy = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ((i % 40) < 28)};
      step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           sy, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 4095)) - 2048, ($urandom_range(0, 15) == 0));
      n_checks++;
      if (obs !== e_vec || oCoefPending !== e_pend) begin
        n_fail++;
        $display("FAIL random_%0d: got out=%h pend=%b expected out=%h pend=%b",
                 i, obs, oCoefPending, e_vec, e_pend);
      end
    end
  endtask

  task automatic test_reset_midframe();
    step(10, 20, 30, 4'b0011, 1'b0, 0, 0, 1'b0);
    step(255, 0, 0, 4'b0011, 1'b1, 0, 1024, 1'b1);
    step(40, 50, 60, 4'b0011, 1'b0, 0, 0, 1'b0);
    iRst_n = 1'b0;
    @(posedge iClk); #1;
    n_checks++;
    if (obs !== 28'h0 || oCoefPending !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: got out=%h pend=%b expected 0", obs, oCoefPending);
    end
    model_reset();
    iRst_n = 1'b1;
    step(255, 0, 0, 4'b0011, 1'b0, 0, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 4'b0011, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== e_vec) begin
        n_fail++;
        $display("FAIL after_reset_cycle%0d: got %h expected %h", c, obs, e_vec);
      end
    end
    n_checks++;
    if ({oC0, oC1, oC2} !== {8'd76, 8'd85, 8'd255}) begin
      n_fail++;
      $display("FAIL after_reset_defaults: got %0d,%0d,%0d expected 76,85,255", oC0, oC1, oC2);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_coef_update();
    test_hsync();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
